// File: rtl/seven_segment_point_editor.sv
// Cursor-driven editor for the decimal points of a multi-digit seven-segment display.
// Buttons step the cursor or toggle the point under it; a held step button auto-repeats.
module seven_segment_point_editor #(
  parameter int DIGITS        = 8,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int BLINK_CYCLES  = 25_000_000,
  localparam int CW           = $clog2(DIGITS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              leftButton,
  input  logic              rightButton,
  input  logic              toggleButton,
  output logic [DIGITS-1:0] pointEnable,
  output logic [CW-1:0]     currentPoint,
  output logic [DIGITS-1:0] cursorOneHot,
  output logic [DIGITS-1:0] pointDisplay
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(BLINK_CYCLES + 1);

  localparam logic [CNTW-1:0] HOLD_LAST   = CNTW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] REPEAT_LAST = CNTW'(REPEAT_CYCLES - 1);
  localparam logic [BW-1:0]   BLINK_LAST  = BW'(BLINK_CYCLES - 1);
  localparam logic [CW-1:0]   LAST_IDX    = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t            state_q;
  logic              dir_q;
  logic [CNTW-1:0]   cnt_q;
  logic              left_q, right_q, toggle_q;
  logic [DIGITS-1:0] point_q, point_d;
  logic [CW-1:0]     cur_q, cur_d;
  logic [BW-1:0]     blink_cnt_q;
  logic              blink_phase_q;

  logic              left_edge, right_edge, toggle_edge;
  logic              dir_level, rep_fire, step_up, step_dn, do_toggle;
  logic [CNTW-1:0]   rep_limit;

  always_comb begin
    left_edge   = leftButton & ~left_q;
    right_edge  = rightButton & ~right_q;
    toggle_edge = toggleButton & ~toggle_q;

    // dir_q = 0 means the left button owns the repeat, 1 means the right one
    dir_level = dir_q ? rightButton : leftButton;
    rep_limit = (state_q == HOLD) ? HOLD_LAST : REPEAT_LAST;
    rep_fire  = (state_q != IDLE) && dir_level && (cnt_q == rep_limit);

    step_up   = left_edge | (~right_edge & rep_fire & ~dir_q);
    step_dn   = ~left_edge & (right_edge | (rep_fire & dir_q));
    do_toggle = toggle_edge & ~left_edge & ~right_edge & ~rep_fire;

    cur_d = cur_q;
    if (step_up) begin
      if (cur_q == LAST_IDX) cur_d = (WRAP != 0) ? '0 : LAST_IDX;
      else                   cur_d = cur_q + CW'(1);
    end else if (step_dn) begin
      if (cur_q == '0) cur_d = (WRAP != 0) ? LAST_IDX : '0;
      else             cur_d = cur_q - CW'(1);
    end

    point_d = do_toggle ? (point_q ^ cursorOneHot) : point_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      dir_q         <= 1'b0;
      cnt_q         <= '0;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      toggle_q      <= 1'b0;
      point_q       <= '0;
      cur_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      left_q   <= leftButton;
      right_q  <= rightButton;
      toggle_q <= toggleButton;
      point_q  <= point_d;
      cur_q    <= cur_d;

      // Restarting the blink on every move keeps the new cursor position visible at once
      if (cur_d != cur_q) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end

      if ((left_edge || right_edge) && (HOLD_CYCLES != 0)) begin
        state_q <= HOLD;
        dir_q   <= ~left_edge;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          HOLD, REPEAT: begin
            if (!dir_level) begin
              state_q <= IDLE;
            end else if (rep_fire) begin
              state_q <= REPEAT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_decode
    assign cursorOneHot[gi] = (cur_q == CW'(gi));
    assign pointDisplay[gi] = point_q[gi] ^ (blink_phase_q & cursorOneHot[gi]);
  end

  assign pointEnable  = point_q;
  assign currentPoint = cur_q;

endmodule

// File: tb/tb_seven_segment_point_editor.sv
// Bench for the point editor: a wrapping and a saturating instance share one stimulus
// stream; a behavioural model feeds a scoreboard queue, plus directed scenario checks.
module tb_seven_segment_point_editor;

  localparam int D = 6;
  localparam int H = 4;
  localparam int R = 2;
  localparam int B = 3;

  logic clock, reset, leftButton, rightButton, toggleButton;
  logic [D-1:0] pe_w, oh_w, disp_w, pe_s, oh_s, disp_s;
  logic [2:0]   cur_w, cur_s;

  int checks   = 0;
  int failures = 0;

  seven_segment_point_editor #(
    .DIGITS(D), .WRAP(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .BLINK_CYCLES(B)
  ) dut_w (
    .clock(clock), .reset(reset), .leftButton(leftButton), .rightButton(rightButton),
    .toggleButton(toggleButton), .pointEnable(pe_w), .currentPoint(cur_w),
    .cursorOneHot(oh_w), .pointDisplay(disp_w)
  );

  seven_segment_point_editor #(
    .DIGITS(D), .WRAP(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .BLINK_CYCLES(B)
  ) dut_s (
    .clock(clock), .reset(reset), .leftButton(leftButton), .rightButton(rightButton),
    .toggleButton(toggleButton), .pointEnable(pe_s), .currentPoint(cur_s),
    .cursorOneHot(oh_s), .pointDisplay(disp_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [D-1:0] pe;
    int           cur;
    logic         pl, pr, pt;
    int           st;    // 0 idle, 1 hold, 2 repeat
    logic         dir;   // 0 left, 1 right
    int           cnt;
    int           bcnt;
    logic         ph;
  } mstate_t;

  typedef struct packed {
    logic [D-1:0] pe;
    logic [2:0]   cur;
    logic [D-1:0] oh;
    logic [D-1:0] disp;
  } obs_t;

  typedef struct packed {
    obs_t w;
    obs_t s;
  } exp_t;

  mstate_t mw = '0;
  mstate_t ms = '0;
  exp_t    sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mstate_t mnext(mstate_t s, logic l, logic r, logic t, logic rs, logic wrap);
    mstate_t n;
    logic el, er, et, held;
    int mv, lim;
    n  = s;
    mv = 0;
    if (rs) return '0;
    el = l && !s.pl;
    er = r && !s.pr;
    et = t && !s.pt;
    n.pl = l; n.pr = r; n.pt = t;
    if (el) begin
      mv = 1; n.st = 1; n.dir = 1'b0; n.cnt = 0;
    end else if (er) begin
      mv = -1; n.st = 1; n.dir = 1'b1; n.cnt = 0;
    end else if (s.st != 0) begin
      held = s.dir ? r : l;
      lim  = (s.st == 1) ? H : R;
      if (!held) n.st = 0;
      else if (s.cnt == lim - 1) begin
        mv = s.dir ? -1 : 1; n.cnt = 0; n.st = 2;
      end else n.cnt = s.cnt + 1;
    end
    if (mv == 0 && et) n.pe[s.cur] = ~s.pe[s.cur];
    if (mv == 1)  n.cur = (s.cur == D - 1) ? (wrap ? 0 : D - 1) : s.cur + 1;
    if (mv == -1) n.cur = (s.cur == 0) ? (wrap ? D - 1 : 0) : s.cur - 1;
    if (n.cur != s.cur) begin
      n.bcnt = 0; n.ph = 1'b0;
    end else if (s.bcnt == B - 1) begin
      n.bcnt = 0; n.ph = ~s.ph;
    end else n.bcnt = s.bcnt + 1;
    return n;
  endfunction

  function automatic obs_t mobs(mstate_t s);
    obs_t o;
    o.pe   = s.pe;
    o.cur  = 3'(s.cur);
    o.oh   = D'(1) << s.cur;
    o.disp = s.pe ^ (s.ph ? o.oh : '0);
    return o;
  endfunction

  task automatic tick(input logic l, input logic r, input logic t, input logic rs);
    exp_t e;
    leftButton = l; rightButton = r; toggleButton = t; reset = rs;
    mw = mnext(mw, l, r, t, rs, 1'b1);
    ms = mnext(ms, l, r, t, rs, 1'b0);
    e.w = mobs(mw);
    e.s = mobs(ms);
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_val("w_pe",   32'(pe_w),   32'(e.w.pe));
    check_val("w_cur",  32'(cur_w),  32'(e.w.cur));
    check_val("w_oh",   32'(oh_w),   32'(e.w.oh));
    check_val("w_disp", 32'(disp_w), 32'(e.w.disp));
    check_val("s_pe",   32'(pe_s),   32'(e.s.pe));
    check_val("s_cur",  32'(cur_s),  32'(e.s.cur));
    check_val("s_oh",   32'(oh_s),   32'(e.s.oh));
    check_val("s_disp", 32'(disp_s), 32'(e.s.disp));
  endtask

  task automatic pulse(input logic l, input logic r, input logic t);
    tick(l, r, t, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int rep_cur[11] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5};

  initial begin
    leftButton = 0; rightButton = 0; toggleButton = 0; reset = 1;

    // Reset state
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    check_val("rst_cur", 32'(cur_w), 32'd0);
    check_val("rst_oh",  32'(oh_w),  32'b000001);
    check_val("rst_disp", 32'(disp_w), 32'd0);
    check_val("rst_pe",  32'(pe_w),  32'd0);

    // Right at 0: wrap goes to 5, saturate holds 0
    tick(0, 1, 0, 0);
    check_val("wrap_dn_w", 32'(cur_w), 32'd5);
    check_val("sat_dn_s",  32'(cur_s), 32'd0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    check_val("wrap_up_w",  32'(cur_w), 32'd0);
    check_val("wrap_up_oh", 32'(oh_w),  32'b000001);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    check_val("wrap_dn2_w", 32'(cur_w), 32'd5);
    tick(0, 0, 0, 0);

    // Saturating instance at 0: five lefts reach 5, a sixth holds 5
    for (int i = 0; i < 5; i++) pulse(1, 0, 0);
    check_val("sat_five_s", 32'(cur_s), 32'd5);
    pulse(1, 0, 0);
    check_val("sat_six_s", 32'(cur_s), 32'd5);

    // Same-cycle priority at cursor 2
    tick(0, 0, 0, 1);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    tick(1, 1, 1, 0);
    check_val("prio_cur", 32'(cur_w), 32'd3);
    check_val("prio_pe",  32'(pe_w),  32'd0);
    tick(0, 0, 0, 0);

    // Auto-repeat: left held 11 cycles from 0
    tick(0, 0, 0, 1);
    for (int k = 0; k < 11; k++) begin
      tick(1, 0, 0, 0);
      check_val($sformatf("rep_w_c%0d", k), 32'(cur_w), 32'(rep_cur[k]));
    end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 0);
      check_val("rep_rel", 32'(cur_w), 32'd5);
    end

    // Toggle and blink at cursor 1
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    check_val("tog_pe",    32'(pe_w),   32'b000010);
    check_val("blink_on0", 32'(disp_w), 32'b000010);
    tick(0, 0, 0, 0);
    check_val("blink_on1", 32'(disp_w), 32'b000010);
    tick(0, 0, 0, 0);
    check_val("blink_on2", 32'(disp_w), 32'b000010);
    tick(0, 0, 0, 0);
    check_val("blink_off", 32'(disp_w), 32'b000000);

    // Reset while in REPEAT with points 101010
    tick(0, 0, 0, 1);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    check_val("mid_pe", 32'(pe_w), 32'b101010);
    for (int k = 0; k < 6; k++) tick(1, 0, 0, 0);
    check_val("mid_cur", 32'(cur_w), 32'd1);
    tick(1, 0, 0, 1);
    check_val("mrst_pe",   32'(pe_w),   32'd0);
    check_val("mrst_cur",  32'(cur_w),  32'd0);
    check_val("mrst_oh",   32'(oh_w),   32'b000001);
    check_val("mrst_disp", 32'(disp_w), 32'd0);
    tick(1, 0, 0, 0);
    check_val("mrst_edge", 32'(cur_w), 32'd1);
    tick(1, 0, 0, 0);
    check_val("mrst_hold", 32'(cur_w), 32'd1);
    tick(0, 0, 0, 0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      tick(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
